// File: rtl/rob_multiret_if.sv
// Reorder-buffer bus bundle: decode allocation, writeback ports, CSR trap vector
// and the registered retire/flush/CSR outputs of rob_multiret.
//   slave  : used by rob_multiret (decode/wb/csr_tvec in, rob_* out)
//   master : used by the surrounding pipeline or a testbench (the opposite directions)
interface rob_multiret_if #(
  parameter int unsigned IDW      = 7,
  parameter int unsigned RET_W    = 2,
  parameter int unsigned WB_PORTS = 2
);
  logic                    decode_valid;
  logic                    decode_error;
  logic [1:0]              decode_ecause;
  logic [6:0]              decode_retop;
  logic [29:0]             decode_addr;
  logic [5:0]              decode_rd;
  logic                    decode_bptaken;
  logic [29:0]             decode_target;
  logic                    rob_full;
  logic                    rob_empty;
  logic [IDW-1:0]          rob_robid;
  logic [WB_PORTS-1:0]     wb_valid;
  logic [WB_PORTS-1:0]     wb_error;
  logic [IDW*WB_PORTS-1:0] wb_robid;
  logic [5*WB_PORTS-1:0]   wb_ecause;
  logic [32*WB_PORTS-1:0]  wb_result;
  logic [29:0]             csr_tvec;
  logic                    rob_flush;
  logic [29:0]             rob_flush_pc;
  logic [RET_W-1:0]        rob_ret_valid;
  logic [RET_W-1:0]        rob_ret_commit;
  logic [5*RET_W-1:0]      rob_ret_rd;
  logic [32*RET_W-1:0]     rob_ret_result;
  logic                    rob_ret_branch;
  logic                    rob_ret_bptaken;
  logic                    rob_ret_store;
  logic                    rob_csr_valid;
  logic [29:0]             rob_csr_epc;
  logic [4:0]              rob_csr_ecause;
  logic [31:0]             rob_csr_tval;

  modport slave (
    input  decode_valid, decode_error, decode_ecause, decode_retop, decode_addr, decode_rd,
           decode_bptaken, decode_target, wb_valid, wb_error, wb_robid, wb_ecause, wb_result,
           csr_tvec,
    output rob_full, rob_empty, rob_robid, rob_flush, rob_flush_pc, rob_ret_valid,
           rob_ret_commit, rob_ret_rd, rob_ret_result, rob_ret_branch, rob_ret_bptaken,
           rob_ret_store, rob_csr_valid, rob_csr_epc, rob_csr_ecause, rob_csr_tval
  );

  modport master (
    output decode_valid, decode_error, decode_ecause, decode_retop, decode_addr, decode_rd,
           decode_bptaken, decode_target, wb_valid, wb_error, wb_robid, wb_ecause, wb_result,
           csr_tvec,
    input  rob_full, rob_empty, rob_robid, rob_flush, rob_flush_pc, rob_ret_valid,
           rob_ret_commit, rob_ret_rd, rob_ret_result, rob_ret_branch, rob_ret_bptaken,
           rob_ret_store, rob_csr_valid, rob_csr_epc, rob_csr_ecause, rob_csr_tval
  );
endinterface

// File: rtl/rob_multiret.sv
// Multi-retire reorder buffer. One allocation per cycle from decode, WB_PORTS writebacks per
// cycle, up to RET_W in-order retirements per cycle with a registered retire/flush/CSR view.
// Ports: clk, rst (synchronous, active-high), bus (rob_multiret_if.slave, all decode, writeback,
// retire, flush and CSR signals).
// Optional feature: define ROB_CSR_TVAL_EN to keep a per-entry trap value (the result of an
// erroring writeback) and present it on rob_csr_tval; otherwise rob_csr_tval is tied to 0.
module rob_multiret #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned IDW      = 7,
  parameter int unsigned RET_W    = 2,
  parameter int unsigned WB_PORTS = 2
) (
  input logic           clk,
  input logic           rst,
  rob_multiret_if.slave bus
);
  // Pointers are {polarity, index}; the extra bit separates full from empty.
  logic [IDW:0]   head_q, tail_q, count;
  logic [IDW-1:0] head_idx, tail_idx;
  logic           full, alloc, flush_q;

  // Entry storage; op = {branch, invert, jump, store}.
  logic           ent_exec   [DEPTH];
  logic           ent_err    [DEPTH];
  logic [4:0]     ent_ecause [DEPTH];
  logic [31:0]    ent_result [DEPTH];
  logic [3:0]     ent_op     [DEPTH];
  logic [29:0]    ent_addr   [DEPTH];
  logic [5:0]     ent_rd     [DEPTH];
  logic           ent_bpt    [DEPTH];
  logic [29:0]    ent_tgt    [DEPTH];
`ifdef ROB_CSR_TVAL_EN
  logic [31:0]    ent_tval   [DEPTH];
`endif

  logic [2:0]     unused_retop;
  assign unused_retop = bus.decode_retop[2:0];

  assign head_idx      = head_q[IDW-1:0];
  assign tail_idx      = tail_q[IDW-1:0];
  assign full          = (head_idx == tail_idx) && (head_q[IDW] != tail_q[IDW]);
  assign count         = tail_q - head_q;
  assign alloc         = bus.decode_valid & ~full & ~flush_q;
  assign bus.rob_full  = full;
  assign bus.rob_empty = (head_q == tail_q);
  assign bus.rob_robid = tail_idx;

  // Retire selection and next-cycle output values.
  logic [RET_W-1:0]   ret_valid_d, commit_d;
  logic [5*RET_W-1:0] rd_d;
  logic [32*RET_W-1:0] result_d;
  logic               branch_d, bpt_d, store_d, flush_d, csr_valid_d;
  logic [29:0]        flush_pc_d, epc_d;
  logic [4:0]         ecause_d;
  logic [31:0]        tval_d;
  logic [2:0]         nsel;
  logic               go, seen_br, seen_st, lflush;
  logic [IDW-1:0]     idx;

  always_comb begin
    ret_valid_d = '0;
    commit_d    = '0;
    rd_d        = '0;
    result_d    = '0;
    branch_d    = 1'b0;
    bpt_d       = 1'b0;
    store_d     = 1'b0;
    flush_d     = 1'b0;
    flush_pc_d  = '0;
    csr_valid_d = 1'b0;
    epc_d       = '0;
    ecause_d    = '0;
    tval_d      = '0;
    nsel        = '0;
    go          = ~flush_q;
    seen_br     = 1'b0;
    seen_st     = 1'b0;
    lflush      = 1'b0;
    idx         = head_idx;
    for (int i = 0; i < RET_W; i++) begin
      idx = head_idx + IDW'(i);
      // A lane is taken only if every earlier lane was taken and no flush happened before it.
      if (go && ((IDW+1)'(i) < count) && ent_exec[idx] && !(ent_op[idx][3] && seen_br) &&
          !(ent_op[idx][0] && seen_st)) begin
        nsel    = nsel + 3'd1;
        seen_br = seen_br | ent_op[idx][3];
        seen_st = seen_st | ent_op[idx][0];
        if (ent_err[idx]) begin
          csr_valid_d = 1'b1;
          epc_d       = ent_addr[idx];
          ecause_d    = ent_ecause[idx];
`ifdef ROB_CSR_TVAL_EN
          tval_d      = ent_tval[idx];
`endif
        end else begin
          ret_valid_d[i]       = 1'b1;
          commit_d[i]          = ~ent_rd[idx][5];
          rd_d[5*i +: 5]       = ent_rd[idx][4:0];
          result_d[32*i +: 32] = ent_result[idx];
          if (ent_op[idx][3]) begin
            branch_d = 1'b1;
            bpt_d    = ent_result[idx][0] ^ ent_op[idx][2];
          end
          if (ent_op[idx][0]) store_d = 1'b1;
        end
        lflush = ent_err[idx] | ent_op[idx][1] |
                 (ent_op[idx][3] & ((ent_result[idx][0] ^ ent_op[idx][2]) != ent_bpt[idx]));
        if (lflush) begin
          flush_d    = 1'b1;
          flush_pc_d = ent_err[idx] ? bus.csr_tvec : ent_tgt[idx];
          go         = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  // Pointers and registered outputs.
  logic [RET_W-1:0]    ret_valid_q, commit_q;
  logic [5*RET_W-1:0]  rd_q;
  logic [32*RET_W-1:0] result_q;
  logic                branch_q, bpt_q, store_q, csr_valid_q;
  logic [29:0]         flush_pc_q, epc_q;
  logic [4:0]          ecause_q;
  logic [31:0]         tval_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      flush_q     <= 1'b0;
      ret_valid_q <= '0;
      commit_q    <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      branch_q    <= 1'b0;
      bpt_q       <= 1'b0;
      store_q     <= 1'b0;
      flush_pc_q  <= '0;
      csr_valid_q <= 1'b0;
      epc_q       <= '0;
      ecause_q    <= '0;
      tval_q      <= '0;
    end else begin
      ret_valid_q <= ret_valid_d;
      commit_q    <= commit_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      branch_q    <= branch_d;
      bpt_q       <= bpt_d;
      store_q     <= store_d;
      flush_q     <= flush_d;
      flush_pc_q  <= flush_pc_d;
      csr_valid_q <= csr_valid_d;
      epc_q       <= epc_d;
      ecause_q    <= ecause_d;
      tval_q      <= tval_d;
      if (flush_q) begin
        // Whole buffer is discarded while the flush is visible.
        head_q <= '0;
        tail_q <= '0;
      end else begin
        head_q <= head_q + (IDW+1)'(nsel);
        if (alloc) tail_q <= tail_q + 1'b1;
      end
    end
  end

  assign bus.rob_ret_valid   = ret_valid_q;
  assign bus.rob_ret_commit  = commit_q;
  assign bus.rob_ret_rd      = rd_q;
  assign bus.rob_ret_result  = result_q;
  assign bus.rob_ret_branch  = branch_q;
  assign bus.rob_ret_bptaken = bpt_q;
  assign bus.rob_ret_store   = store_q;
  assign bus.rob_flush       = flush_q;
  assign bus.rob_flush_pc    = flush_pc_q;
  assign bus.rob_csr_valid   = csr_valid_q;
  assign bus.rob_csr_epc     = epc_q;
  assign bus.rob_csr_ecause  = ecause_q;
  assign bus.rob_csr_tval    = tval_q;

  // Entry writes: later assignments win, so higher WB ports beat lower ones and a same-cycle
  // dispatch beats any writeback.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p]) begin
        ent_exec[bus.wb_robid[p*IDW +: IDW]]   <= 1'b1;
        ent_err[bus.wb_robid[p*IDW +: IDW]]    <= bus.wb_error[p];
        ent_ecause[bus.wb_robid[p*IDW +: IDW]] <= bus.wb_ecause[5*p +: 5];
        ent_result[bus.wb_robid[p*IDW +: IDW]] <= bus.wb_result[32*p +: 32];
`ifdef ROB_CSR_TVAL_EN
        if (bus.wb_error[p]) ent_tval[bus.wb_robid[p*IDW +: IDW]] <= bus.wb_result[32*p +: 32];
`endif
      end
    end
    if (alloc) begin
      ent_exec[tail_idx]   <= bus.decode_error | bus.decode_retop[3];
      ent_err[tail_idx]    <= bus.decode_error;
      ent_ecause[tail_idx] <= {3'b0, bus.decode_ecause};
      ent_result[tail_idx] <= '0;
      ent_op[tail_idx]     <= bus.decode_retop[6:3];
      ent_addr[tail_idx]   <= bus.decode_addr;
      ent_rd[tail_idx]     <= bus.decode_rd;
      ent_bpt[tail_idx]    <= bus.decode_bptaken;
      ent_tgt[tail_idx]    <= bus.decode_target;
`ifdef ROB_CSR_TVAL_EN
      ent_tval[tail_idx]   <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_rob_multiret.sv
module tb_rob_multiret;
  localparam int unsigned DEPTH = 128, IDW = 7, RET_W = 2, WB_PORTS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_multiret_if #(.IDW(IDW), .RET_W(RET_W), .WB_PORTS(WB_PORTS)) bus ();
  rob_multiret #(.DEPTH(DEPTH), .IDW(IDW), .RET_W(RET_W), .WB_PORTS(WB_PORTS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int          id;
    logic [29:0] addr, tgt;
    logic [5:0]  rd;
    logic        br, inv, jmp, st, bpt, exec, err;
    logic [4:0]  ec;
    logic [31:0] res, tval;
  } ent_t;

  typedef struct {
    logic [RET_W-1:0]    rv, cm;
    logic [5*RET_W-1:0]  rd;
    logic [32*RET_W-1:0] res;
    logic                br, bpt, st, fl, cv;
    logic [29:0]         fpc, epc;
    logic [4:0]          ec;
    logic [31:0]         tval;
  } pkt_t;

  ent_t mq[$];    // occupied entries, oldest first
  pkt_t exq[$];   // expected retire packets
  int   m_tail;
  bit   m_flush;
  int   errors = 0, checks = 0;

  // Stimulus for the next cycle.
  logic                d_valid, d_err, d_bpt;
  logic [1:0]          d_ec;
  logic [6:0]          d_op;
  logic [29:0]         d_addr, d_tgt, tvec;
  logic [5:0]          d_rd;
  logic [WB_PORTS-1:0] w_v, w_err;
  logic [IDW-1:0]      w_id  [WB_PORTS];
  logic [4:0]          w_ec  [WB_PORTS];
  logic [31:0]         w_res [WB_PORTS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    d_valid = 1'b0;
    d_err   = 1'b0;
    d_op    = '0;
    w_v     = '0;
    w_err   = '0;
  endtask

  task automatic drive();
    bus.decode_valid   = d_valid;
    bus.decode_error   = d_err;
    bus.decode_ecause  = d_ec;
    bus.decode_retop   = d_op;
    bus.decode_addr    = d_addr;
    bus.decode_rd      = d_rd;
    bus.decode_bptaken = d_bpt;
    bus.decode_target  = d_tgt;
    bus.csr_tvec       = tvec;
    for (int p = 0; p < WB_PORTS; p++) begin
      bus.wb_valid[p]              = w_v[p];
      bus.wb_error[p]              = w_err[p];
      bus.wb_robid[p*IDW +: IDW]   = w_id[p];
      bus.wb_ecause[5*p +: 5]      = w_ec[p];
      bus.wb_result[32*p +: 32]    = w_res[p];
    end
  endtask

  // Reference model: one clock edge of ROB behaviour applied to the queue of live entries.
  task automatic model_step();
    pkt_t p;
    ent_t e;
    int   nsel;
    bit   nb, ns, fl, was_full, found;
    if (m_flush) begin
      mq.delete();
      m_tail  = 0;
      m_flush = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    p = '{default: '0};
    nsel = 0; nb = 0; ns = 0; fl = 0;
    for (int i = 0; i < RET_W && i < mq.size(); i++) begin
      e = mq[i];
      if (!e.exec || (e.br && nb) || (e.st && ns)) break;
      nsel++;
      nb |= e.br;
      ns |= e.st;
      if (e.err) begin
        p.cv = 1; p.epc = e.addr; p.ec = e.ec; p.tval = e.tval;
      end else begin
        p.rv[i] = 1;
        p.cm[i] = !e.rd[5];
        p.rd[5*i +: 5] = e.rd[4:0];
        p.res[32*i +: 32] = e.res;
        if (e.br) begin p.br = 1; p.bpt = e.res[0] ^ e.inv; end
        if (e.st) p.st = 1;
      end
      if (e.err || e.jmp || (e.br && ((e.res[0] ^ e.inv) != e.bpt))) begin
        p.fl = 1;
        p.fpc = e.err ? tvec : e.tgt;
        fl = 1;
        break;
      end
    end
    if (nsel > 0) exq.push_back(p);
    repeat (nsel) void'(mq.pop_front());
    m_flush = fl;
    for (int q = 0; q < WB_PORTS; q++) begin
      if (w_v[q]) begin
        found = 0;
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].id == int'(w_id[q])) begin
            e = mq[j];
            e.exec = 1; e.err = w_err[q]; e.ec = w_ec[q]; e.res = w_res[q];
`ifdef ROB_CSR_TVAL_EN
            if (w_err[q]) e.tval = w_res[q];
`endif
            mq[j] = e;
            found = 1;
          end
        end
        assert (found) else $error("FAIL illegal_wb: id %0d not allocated", w_id[q]);
      end
    end
    if (d_valid && !was_full) begin
      e = '{default: '0};
      e.id = m_tail; e.addr = d_addr; e.tgt = d_tgt; e.rd = d_rd; e.bpt = d_bpt;
      e.br = d_op[6]; e.inv = d_op[5]; e.jmp = d_op[4]; e.st = d_op[3];
      e.err = d_err; e.exec = d_err | d_op[3]; e.ec = {3'b0, d_ec};
      mq.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    drive();
    #1;
    check("rob_empty", 64'(bus.rob_empty), 64'(mq.size() == 0));
    check("rob_full", 64'(bus.rob_full), 64'(mq.size() == DEPTH));
    check("rob_robid", 64'(bus.rob_robid), 64'(m_tail));
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alloc(input logic [6:0] op, input logic bpt, input logic [29:0] tgt);
    idle();
    d_valid = 1'b1; d_op = op; d_bpt = bpt; d_tgt = tgt;
    d_addr = 30'($urandom); d_rd = 6'($urandom);
    tick();
  endtask

  task automatic set_wb(input int p, input int id, input logic err, input logic [4:0] ec,
                        input logic [31:0] res);
    w_v[p] = 1'b1; w_id[p] = IDW'(id); w_err[p] = err; w_ec[p] = ec; w_res[p] = res;
  endtask

  task automatic rand_inputs();
    int r;
    int cand[$];
    idle();
    d_valid = ($urandom_range(0, 3) != 0);
    d_err   = ($urandom_range(0, 39) == 0);
    d_ec    = 2'($urandom);
    d_op    = 7'($urandom_range(0, 7));
    r = $urandom_range(0, 19);
    if (r < 4) d_op[6:5] = {1'b1, 1'($urandom)};
    else if (r == 4) d_op[4] = 1'b1;
    else if (r < 9) d_op[3] = 1'b1;
    d_addr = 30'($urandom); d_tgt = 30'($urandom); d_rd = 6'($urandom);
    d_bpt  = 1'($urandom); tvec = 30'($urandom);
    foreach (mq[j]) if (!mq[j].exec) cand.push_back(mq[j].id);
    for (int p = 0; p < WB_PORTS; p++) begin
      if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
        if (p > 0 && w_v[0] && $urandom_range(0, 3) == 0) set_wb(p, int'(w_id[0]), 1'b0, 5'd0, 0);
        else set_wb(p, cand[$urandom_range(0, cand.size() - 1)], 1'b0, 5'd0, 0);
        w_err[p] = ($urandom_range(0, 19) == 0);
        w_ec[p]  = 5'($urandom);
        w_res[p] = $urandom;
      end
    end
  endtask

  // Monitor: every retire/CSR event shown by the DUT is matched against the next expectation.
  initial begin
    pkt_t p;
    forever begin
      @(negedge clk);
      if (!rst && ((|bus.rob_ret_valid) || bus.rob_csr_valid)) begin
        if (exq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got ret_valid=0x%0h csr_valid=%0d, expected none",
                   bus.rob_ret_valid, bus.rob_csr_valid);
        end else begin
          p = exq.pop_front();
          check("ret_valid", 64'(bus.rob_ret_valid), 64'(p.rv));
          check("ret_commit", 64'(bus.rob_ret_commit), 64'(p.cm));
          check("ret_rd", 64'(bus.rob_ret_rd), 64'(p.rd));
          check("ret_result", 64'(bus.rob_ret_result), 64'(p.res));
          check("ret_branch", 64'(bus.rob_ret_branch), 64'(p.br));
          check("ret_bptaken", 64'(bus.rob_ret_bptaken), 64'(p.bpt));
          check("ret_store", 64'(bus.rob_ret_store), 64'(p.st));
          check("flush", 64'(bus.rob_flush), 64'(p.fl));
          check("flush_pc", 64'(bus.rob_flush_pc), 64'(p.fpc));
          check("csr_valid", 64'(bus.rob_csr_valid), 64'(p.cv));
          check("csr_epc", 64'(bus.rob_csr_epc), 64'(p.epc));
          check("csr_ecause", 64'(bus.rob_csr_ecause), 64'(p.ec));
          check("csr_tval", 64'(bus.rob_csr_tval), 64'(p.tval));
        end
      end
    end
  end

  initial begin
    int pulses;
    logic [31:0] exp_tval;
    idle();
    d_ec = '0; d_addr = '0; d_tgt = '0; d_rd = '0; d_bpt = 1'b0; tvec = 30'h0ABC_DE0;
    for (int p = 0; p < WB_PORTS; p++) begin w_id[p] = '0; w_ec[p] = '0; w_res[p] = '0; end
    drive();
    m_tail = 0; m_flush = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ret_valid", 64'(bus.rob_ret_valid), 64'(0));
    check("reset_commit", 64'(bus.rob_ret_commit), 64'(0));
    check("reset_flush", 64'(bus.rob_flush), 64'(0));
    check("reset_csr_valid", 64'(bus.rob_csr_valid), 64'(0));
    check("reset_store_branch", 64'({bus.rob_ret_store, bus.rob_ret_branch}), 64'(0));
    check("reset_empty", 64'(bus.rob_empty), 64'(1));
    check("reset_robid", 64'(bus.rob_robid), 64'(0));
    rst = 1'b0;

    // Four allocations without writeback: ids 0..3, nothing retires.
    for (int i = 0; i < 4; i++) alloc(7'b0, 1'b0, '0);
    idle(); tick();
    check("no_ret_before_wb", 64'(bus.rob_ret_valid), 64'(0));
    check("not_empty", 64'(bus.rob_empty), 64'(0));

    // Dual writeback of ids 0,1 retires both lanes together.
    idle(); set_wb(0, 0, 1'b0, 5'd0, 32'h1111_0000); set_wb(1, 1, 1'b0, 5'd0, 32'h2222_0001);
    tick();
    idle(); tick();
    check("dual_ret_valid", 64'(bus.rob_ret_valid), 64'(2'b11));
    check("dual_ret_result", 64'(bus.rob_ret_result), 64'h2222_0001_1111_0000);
    idle(); set_wb(0, 2, 1'b0, 5'd0, 32'h3); set_wb(1, 3, 1'b0, 5'd0, 32'h4);
    tick();
    idle(); tick();

    // Fill all entries (tail wraps through DEPTH-1), then retire two.
    for (int i = 0; i < DEPTH; i++) alloc(7'b0, 1'b0, '0);
    check("full_after_fill", 64'(bus.rob_full), 64'(1));
    alloc(7'b0, 1'b0, '0);   // rejected while full
    idle(); set_wb(0, mq[0].id, 1'b0, 5'd0, 32'hA); set_wb(1, mq[1].id, 1'b0, 5'd0, 32'hB);
    tick();
    idle(); tick();
    check("full_drops", 64'(bus.rob_full), 64'(0));
    alloc(7'b0, 1'b0, '0);
    alloc(7'b0, 1'b0, '0);

    // Writeback error at head: trap via csr_tvec, whole buffer flushed.
    tvec = 30'h1234_567;
    idle(); set_wb(1, mq[0].id, 1'b1, 5'd5, 32'hDEAD_0000);
    tick();
    idle(); tick();
`ifdef ROB_CSR_TVAL_EN
    exp_tval = 32'hDEAD_0000;
`else
    exp_tval = 32'h0;
`endif
    check("err_csr_valid", 64'(bus.rob_csr_valid), 64'(1));
    check("err_ecause", 64'(bus.rob_csr_ecause), 64'(5));
    check("err_flush_pc", 64'(bus.rob_flush_pc), 64'(30'h1234_567));
    check("err_tval", 64'(bus.rob_csr_tval), 64'(exp_tval));
    check("err_no_ret_valid", 64'(bus.rob_ret_valid), 64'(0));
    idle(); tick();
    check("post_flush_empty", 64'(bus.rob_empty), 64'(1));
    check("post_flush_robid", 64'(bus.rob_robid), 64'(0));

    // Mispredicted branch at id0 (predicted taken, resolved not taken).
    alloc(7'b100_0000, 1'b1, 30'h0BEE_F00);
    alloc(7'b0, 1'b0, '0);
    idle(); set_wb(0, 0, 1'b0, 5'd0, 32'h0); set_wb(1, 1, 1'b0, 5'd0, 32'h55);
    tick();
    idle(); tick();
    check("br_lane0_only", 64'(bus.rob_ret_valid), 64'(2'b01));
    check("br_flush", 64'(bus.rob_flush), 64'(1));
    check("br_flush_pc", 64'(bus.rob_flush_pc), 64'(30'h0BEE_F00));
    check("br_bptaken", 64'(bus.rob_ret_bptaken), 64'(0));
    idle(); tick();
    check("br_post_empty", 64'(bus.rob_empty), 64'(1));
    check("br_post_robid", 64'(bus.rob_robid), 64'(0));

    // Plain op then two executed stores: the stores must retire in separate cycles.
    alloc(7'b0, 1'b0, '0);
    alloc(7'b000_1000, 1'b0, '0);
    alloc(7'b000_1000, 1'b0, '0);
    idle(); set_wb(0, 0, 1'b0, 5'd0, 32'h77);
    tick();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); tick();
      pulses += int'(bus.rob_ret_store);
    end
    check("store_pulses", 64'(pulses), 64'(2));

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end
    idle();
    repeat (4) tick();
    check("scoreboard_drained", 64'(exq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
